router_sync_n: RTL and testbench
================================

ROUTER_SYNC_N -- requirements
Module: router_sync_n

Interface
REQ-001 Parameter NUM_PORTS, 3, number of output ports/FIFOs; legal range 2..2**ADDR_W.
REQ-002 Parameter ADDR_W, 2, width of the destination-address field.
REQ-003 Parameter TIMEOUT, 30, consecutive valid-but-unread cycles before a port soft reset; legal range >= 2.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 detect_add  in  1  address-latch strobe from the router FSM.
REQ-007 write_enb_reg  in  1  FSM request to write the current byte into the selected FIFO.
REQ-008 data_in  in  ADDR_W  destination address, sampled when detect_add=1.
REQ-009 full  in  NUM_PORTS  per-FIFO full flags.
REQ-010 empty  in  NUM_PORTS  per-FIFO empty flags.
REQ-011 read_enb  in  NUM_PORTS  per-port read strobes from the downstream client.
REQ-012 vld_out  out  NUM_PORTS  per-port data-valid.
REQ-013 write_enb  out  NUM_PORTS  one-hot FIFO write enable.
REQ-014 fifo_full  out  1  full flag of the selected FIFO.
REQ-015 soft_reset  out  NUM_PORTS  per-port one-cycle FIFO flush pulse.
REQ-016 addr_err  out  1  latched address is out of range (NUM_PORTS..2**ADDR_W-1).

Function
REQ-017 vld_out[i] SHALL equal ~empty[i], combinational, independent of resetn.
REQ-018 addr_q SHALL load data_in on each rising edge with detect_add=1, else hold.
REQ-019 write_enb SHALL be combinational from addr_q: one-hot bit addr_q when write_enb_reg=1 and addr_q<NUM_PORTS; otherwise all zero.
REQ-020 With detect_add and write_enb_reg both high in one cycle, write_enb SHALL use the pre-edge addr_q.
REQ-021 fifo_full SHALL be combinational full[addr_q] for addr_q<NUM_PORTS.
REQ-022 Per port i, a timeout counter of width $clog2(TIMEOUT+1) SHALL increment on each edge with vld_out[i]=1 and read_enb[i]=0, and clear on any edge with read_enb[i]=1 or vld_out[i]=0.
REQ-023 On the edge where the counter equals TIMEOUT-1 and the increment condition holds, soft_reset[i] SHALL be 1 for exactly the following cycle and the counter SHALL return to 0; the counter never exceeds TIMEOUT-1.
REQ-024 soft_reset[i] SHALL be 0 in every other cycle; ports SHALL time out independently, several in the same cycle if their counts coincide.
REQ-025 read_enb[i]=1 on the edge that would reach TIMEOUT SHALL suppress the pulse and clear the counter.
REQ-026 A read_enb[i] with X/Z value SHALL be treated as not-read.

Reset
REQ-027 With resetn=0 at an edge: addr_q=0, all counters=0, soft_reset=0, addr_err=0.
REQ-028 While resetn=0: write_enb=0 and fifo_full=0, forced combinationally.
REQ-029 Reset mid-count SHALL discard partial counts; counting restarts from 0 on the first edge after release.

Configuration
REQ-030 Macro ROUTER_SYNC_ADDR_CHK_EN defined: addr_err SHALL register (data_in>=NUM_PORTS) on each detect_add edge; fifo_full SHALL be 1 while addr_q>=NUM_PORTS, back-pressuring the FSM into its full/drop path.
REQ-031 Macro undefined: addr_err SHALL be constant 0; fifo_full SHALL be full[0] for addr_q>=NUM_PORTS, matching the legacy 3-port router.

Structure
REQ-032 Package router_pkg SHALL hold ROUTER_NUM_PORTS, ROUTER_ADDR_W and ROUTER_TIMEOUT defaults, shared with the FIFO and FSM blocks.
REQ-033 Sub-module router_sync_wdog (one timeout counter plus soft_reset pulse, parameter TIMEOUT) SHALL be instantiated NUM_PORTS times in a generate loop.

Verification
REQ-034 Defaults; detect_add with data_in=2, then write_enb_reg=1 -> write_enb=3'b100; full=3'b100 -> fifo_full=1.
REQ-035 empty[1]=0, read_enb[1]=0 for 30 edges -> soft_reset=3'b010 for one cycle after edge 30, then 0; counter restarts.
REQ-036 As REQ-035 but read_enb[1]=1 at edge 29 -> no pulse; 30 further unread edges -> pulse.
REQ-037 ROUTER_SYNC_ADDR_CHK_EN defined, detect_add with data_in=3 -> addr_err=1, fifo_full=1, write_enb=0 under write_enb_reg=1; next detect_add with data_in=0 -> addr_err=0.
REQ-038 NUM_PORTS=4, ADDR_W=2, TIMEOUT=5, ports 0 and 3 unread 5 edges -> soft_reset=4'b1001 in the same cycle.
REQ-039 resetn=0 at edge 20 of a count -> soft_reset stays 0; after release a full TIMEOUT edges are needed for a pulse.

Source files
------------

// File: rtl/router_pkg.sv
// Shared defaults for the router slice: port count, address width and watchdog timeout.
// The FIFO, FSM and sync blocks all pull their default parameters from here.
package router_pkg;

    localparam int ROUTER_NUM_PORTS = 3;
    localparam int ROUTER_ADDR_W    = 2;
    localparam int ROUTER_TIMEOUT   = 30;

    // A counter that must hold values up to TIMEOUT needs this many bits.
    function automatic int wdog_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/router_sync_wdog.sv
// One per-port stall watchdog: counts valid-but-unread cycles and emits a one-cycle
// soft_reset pulse when TIMEOUT consecutive stalled edges have been seen.
module router_sync_wdog
    import router_pkg::*;
#(
    parameter int TIMEOUT = ROUTER_TIMEOUT
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic read_enb,
    output logic soft_reset
);

    localparam int CW = wdog_cnt_w(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;
    logic          soft_reset_q, soft_reset_d;
    logic          read_hit;
    logic          stall;

    // An unknown strobe falls through to the not-read branch.
    always_comb begin
        read_hit = 1'b0;
        if (read_enb) read_hit = 1'b1;
    end

    assign stall = vld & ~read_hit;

    always_comb begin
        count_d      = '0;
        soft_reset_d = 1'b0;
        if (resetn && stall) begin
            if (count_q == LAST) begin
                soft_reset_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        count_q      <= count_d;
        soft_reset_q <= soft_reset_d;
    end

    assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the destination address, steers FIFO writes and full
// status, and runs one stall watchdog per output port. Optional ROUTER_SYNC_ADDR_CHK_EN.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_PORTS = ROUTER_NUM_PORTS,
    parameter int ADDR_W    = ROUTER_ADDR_W,
    parameter int TIMEOUT   = ROUTER_TIMEOUT
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 detect_add,
    input  logic                 write_enb_reg,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] full,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 fifo_full,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic                 addr_err
);

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [NUM_PORTS-1:0] sel_oh;
    logic [NUM_PORTS-1:0] din_oh;
    logic                 addr_in_range;
    logic                 din_in_range;
    logic                 sel_full;

    assign vld_out = ~empty;

    always_comb begin
        addr_d = addr_q;
        if (!resetn) begin
            addr_d = '0;
        end else if (detect_add) begin
            addr_d = data_in;
        end
    end

    always_ff @(posedge clock) begin
        addr_q <= addr_d;
    end

    // Decoding by equality against each port keeps out-of-range addresses all-zero.
    always_comb begin
        sel_oh = '0;
        din_oh = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_q == ADDR_W'(i))  sel_oh[i] = 1'b1;
            if (data_in == ADDR_W'(i)) din_oh[i] = 1'b1;
        end
    end

    assign addr_in_range = |sel_oh;
    assign din_in_range  = |din_oh;
    assign sel_full      = |(full & sel_oh);

    always_comb begin
        write_enb = '0;
        if (resetn && write_enb_reg) begin
            write_enb = sel_oh;
        end
    end

`ifdef ROUTER_SYNC_ADDR_CHK_EN
    logic addr_err_q, addr_err_d;

    always_comb begin
        addr_err_d = addr_err_q;
        if (!resetn) begin
            addr_err_d = 1'b0;
        end else if (detect_add) begin
            addr_err_d = ~din_in_range;
        end
    end

    always_ff @(posedge clock) begin
        addr_err_q <= addr_err_d;
    end

    assign addr_err = addr_err_q;

    // A bad address looks full so the FSM takes its drop path instead of writing.
    always_comb begin
        fifo_full = 1'b0;
        if (resetn) begin
            fifo_full = addr_in_range ? sel_full : 1'b1;
        end
    end
`else
    logic unused_din_in_range;
    assign unused_din_in_range = din_in_range;
    assign addr_err = 1'b0;

    // Legacy 3-port behaviour: an unmapped address reports port 0's full flag.
    always_comb begin
        fifo_full = 1'b0;
        if (resetn) begin
            fifo_full = addr_in_range ? sel_full : full[0];
        end
    end
`endif

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_wdog
        router_sync_wdog #(
            .TIMEOUT (TIMEOUT)
        ) u_wdog (
            .clock      (clock),
            .resetn     (resetn),
            .vld        (vld_out[g]),
            .read_enb   (read_enb[g]),
            .soft_reset (soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_sync_n.sv
// Bench for router_sync_n: directed timeout/reset scenarios plus randomized traffic,
// all checked every cycle against a streak-counting reference model.
module tb_router_sync_n;
    import router_pkg::*;

    localparam int NP = ROUTER_NUM_PORTS;
    localparam int AW = ROUTER_ADDR_W;
    localparam int TO = ROUTER_TIMEOUT;
`ifdef ROUTER_SYNC_ADDR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          resetn;
    logic          detect_add;
    logic          write_enb_reg;
    logic [AW-1:0] data_in;
    logic [NP-1:0] full, empty, read_enb;
    logic [NP-1:0] vld_out, write_enb, soft_reset;
    logic          fifo_full, addr_err;

    always #5 clock = ~clock;

    router_sync_n #(.NUM_PORTS(NP), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .write_enb_reg (write_enb_reg),
        .data_in       (data_in),
        .full          (full),
        .empty         (empty),
        .read_enb      (read_enb),
        .vld_out       (vld_out),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .soft_reset    (soft_reset),
        .addr_err      (addr_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: latched address, consecutive stalled edges per port, pending pulses.
    int            m_addr;
    int            m_streak [NP];
    logic [NP-1:0] m_pulse;
    logic          m_err;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [NP-1:0] e_vld;
        logic [31:0]   e_we;
        logic          e_ff;
        e_vld = ~empty;
        e_we  = 0;
        if (resetn && write_enb_reg && m_addr < NP) e_we = 32'd1 << m_addr;
        if (!resetn)          e_ff = 1'b0;
        else if (m_addr < NP) e_ff = full[m_addr];
        else                  e_ff = CHK ? 1'b1 : full[0];
        expect_eq("vld_out",    32'(vld_out),    32'(e_vld));
        expect_eq("write_enb",  32'(write_enb),  e_we);
        expect_eq("fifo_full",  32'(fifo_full),  32'(e_ff));
        expect_eq("soft_reset", 32'(soft_reset), 32'(m_pulse));
        expect_eq("addr_err",   32'(addr_err),   32'(CHK ? m_err : 1'b0));
    endtask

    task automatic model_edge();
        if (!resetn) begin
            m_addr  = 0;
            m_err   = 1'b0;
            m_pulse = '0;
            for (int i = 0; i < NP; i++) m_streak[i] = 0;
        end else begin
            if (detect_add) begin
                m_addr = int'(data_in);
                m_err  = (m_addr >= NP);
            end
            for (int i = 0; i < NP; i++) begin
                m_pulse[i] = 1'b0;
                if (!empty[i] && !read_enb[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == TO) begin
                        m_pulse[i]  = 1'b1;
                        m_streak[i] = 0;
                    end
                end else begin
                    m_streak[i] = 0;
                end
            end
        end
    endtask

    // Called with inputs just driven (posedge+1); returns at the next posedge+1.
    task automatic tick();
        #1 check_outputs();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        detect_add    = 1'b0;
        write_enb_reg = 1'b0;
        data_in       = '0;
        full          = '0;
        empty         = '1;
        read_enb      = '0;
    endtask

    int pulse_cnt;
    int pulse_at;

    initial begin
        m_addr  = 0;
        m_err   = 1'b0;
        m_pulse = '0;
        for (int i = 0; i < NP; i++) m_streak[i] = 0;
        resetn = 1'b0;
        idle_inputs();
        @(posedge clock);
        model_edge();
        #1;
        tick();
        expect_eq("rst_soft_reset", 32'(soft_reset), 32'd0);
        expect_eq("rst_write_enb",  32'(write_enb),  32'd0);
        resetn = 1'b1;
        tick();

        // Address latch and steering to port 2.
        detect_add = 1'b1;
        data_in    = AW'(2);
        tick();
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = NP'(4);
        #1;
        expect_eq("p2_write_enb", 32'(write_enb), 32'd4);
        expect_eq("p2_fifo_full", 32'(fifo_full), 32'd1);
        tick();

        // Latch and write in the same cycle use the old address.
        detect_add = 1'b1;
        data_in    = AW'(0);
        #1;
        expect_eq("same_cyc_we", 32'(write_enb), 32'd4);
        tick();
        detect_add = 1'b0;
        #1;
        expect_eq("new_addr_we", 32'(write_enb), 32'd1);
        tick();

        // Out-of-range address.
        detect_add = 1'b1;
        data_in    = AW'(3);
        tick();
        detect_add = 1'b0;
        full       = NP'(1);
        #1;
        expect_eq("oor_write_enb", 32'(write_enb), 32'd0);
        tick();
        idle_inputs();
        tick();

        // Port 1 stalled for TO edges: one pulse right after edge TO.
        pulse_cnt = 0;
        pulse_at  = -1;
        empty     = ~NP'(2);
        for (int k = 1; k <= TO + 2; k++) begin
            tick();
            if (soft_reset[1]) begin
                pulse_cnt++;
                pulse_at = k;
            end
        end
        expect_eq("to_pulse_cnt", 32'(pulse_cnt), 32'd1);
        expect_eq("to_pulse_at",  32'(pulse_at),  32'(TO));
        idle_inputs();
        tick();

        // Read on edge TO-1 clears; then TO further stalled edges give the pulse.
        pulse_cnt = 0;
        pulse_at  = -1;
        empty     = ~NP'(2);
        for (int k = 1; k <= 2 * TO + 1; k++) begin
            read_enb = (k == TO - 1) ? NP'(2) : '0;
            tick();
            if (soft_reset[1]) begin
                pulse_cnt++;
                pulse_at = k;
            end
        end
        expect_eq("rd_pulse_cnt", 32'(pulse_cnt), 32'd1);
        expect_eq("rd_pulse_at",  32'(pulse_at),  32'(2 * TO - 1));
        idle_inputs();
        tick();

        // Reset mid-count discards the partial streak.
        pulse_cnt = 0;
        pulse_at  = -1;
        empty     = ~NP'(2);
        for (int k = 1; k <= TO + 22; k++) begin
            resetn = (k == 20) ? 1'b0 : 1'b1;
            tick();
            if (soft_reset[1]) begin
                pulse_cnt++;
                pulse_at = k;
            end
        end
        expect_eq("rst_pulse_cnt", 32'(pulse_cnt), 32'd1);
        expect_eq("rst_pulse_at",  32'(pulse_at),  32'(20 + TO));
        idle_inputs();
        tick();

        // Randomized traffic; empties change rarely so streaks can reach TO.
        for (int k = 0; k < 4000; k++) begin
            resetn        = ($urandom_range(0, 399) != 0);
            detect_add    = ($urandom_range(0, 7) == 0);
            data_in       = AW'($urandom);
            write_enb_reg = 1'($urandom);
            full          = NP'($urandom);
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 39) == 0) empty[i] = ~empty[i];
                read_enb[i] = ($urandom_range(0, 49) == 0);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
